// File: rtl/float_addsub.sv
// -----------------------------------------------------------------------------
// float_addsub: binary32 adder/subtractor, fully pipelined.
// Operands and op are registered on every rising edge. The result appears on
// vres three edges after the edge that sampled them. One new operand pair can
// be accepted on every cycle.
//   sample : register v1, v2, op
//   stage 1: unpack, apply op, resolve special cases, swap larger first
//   stage 2: align the smaller significand (guard/round/sticky), add/subtract
//   stage 3: normalize, round to nearest even, pack
// Subnormal inputs and results below the normal range are flushed to zero.
// -----------------------------------------------------------------------------
module float_addsub (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] v1,
   input  logic [31:0] v2,
   input  logic        op,
   output logic [31:0] vres
);

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [7:0]  EXP_MAX = 8'hFF;

   // ---------------------------------------------------------------------------
   // Sample registers
   // ---------------------------------------------------------------------------
   logic [31:0] a_q, b_q;
   logic        op_q;

   // Capture the raw operands and operation on every edge.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is written only with non-blocking assignments so
      // every stage reads the values from before the edge, never this edge's.
      if (rst) begin
         a_q  <= 32'd0;
         b_q  <= 32'd0;
         op_q <= 1'b0;
      end else begin
         a_q  <= v1;
         b_q  <= v2;
         op_q <= op;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 1: unpack, effective sign of B, special values, magnitude swap
   // ---------------------------------------------------------------------------
   logic        sa, sb;
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic        a_ge;

   assign sa     = a_q[31];
   assign sb     = b_q[31] ^ op_q;
   assign ea     = a_q[30:23];
   assign eb     = b_q[30:23];
   assign fa     = a_q[22:0];
   assign fb     = b_q[22:0];
   assign a_nan  = (ea == EXP_MAX) && (fa != 23'd0);
   assign b_nan  = (eb == EXP_MAX) && (fb != 23'd0);
   assign a_inf  = (ea == EXP_MAX) && (fa == 23'd0);
   assign b_inf  = (eb == EXP_MAX) && (fb == 23'd0);
   // An exponent of zero is either a true zero or a subnormal that is flushed.
   assign a_zero = (ea == 8'd0);
   assign b_zero = (eb == 8'd0);
   assign a_ge   = {ea, fa} >= {eb, fb};

   logic        s1_special_d, s1_special_q;
   logic [31:0] s1_spec_res_d, s1_spec_res_q;
   logic        s1_sign_d, s1_sign_q;
   logic        s1_sub_d, s1_sub_q;
   logic [7:0]  s1_exp_d, s1_exp_q;
   logic [23:0] s1_man_big_d, s1_man_big_q;
   logic [23:0] s1_man_small_d, s1_man_small_q;
   logic [7:0]  s1_diff_d, s1_diff_q;

   // Resolve NaN/Inf/zero operands directly; otherwise order the operands by magnitude.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      s1_special_d  = 1'b1;
      s1_spec_res_d = 32'd0;
      if (a_nan || b_nan) begin
         s1_spec_res_d = QNAN;
      end else if (a_inf && b_inf) begin
         s1_spec_res_d = (sa == sb) ? {sa, EXP_MAX, 23'd0} : QNAN;
      end else if (a_inf) begin
         s1_spec_res_d = {sa, EXP_MAX, 23'd0};
      end else if (b_inf) begin
         s1_spec_res_d = {sb, EXP_MAX, 23'd0};
      end else if (a_zero && b_zero) begin
         // Only (-0) + (-0) keeps the negative sign.
         s1_spec_res_d = {sa & sb, 31'd0};
      end else if (a_zero) begin
         s1_spec_res_d = {sb, eb, fb};
      end else if (b_zero) begin
         s1_spec_res_d = {sa, ea, fa};
      end else begin
         s1_special_d  = 1'b0;
      end

      s1_sub_d = sa ^ sb;
      if (a_ge) begin
         s1_sign_d      = sa;
         s1_exp_d       = ea;
         s1_man_big_d   = {1'b1, fa};
         s1_man_small_d = {1'b1, fb};
         s1_diff_d      = ea - eb;
      end else begin
         s1_sign_d      = sb;
         s1_exp_d       = eb;
         s1_man_big_d   = {1'b1, fb};
         s1_man_small_d = {1'b1, fa};
         s1_diff_d      = eb - ea;
      end
   end

   // Stage 1 pipeline register.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_special_q   <= 1'b0;
         s1_spec_res_q  <= 32'd0;
         s1_sign_q      <= 1'b0;
         s1_sub_q       <= 1'b0;
         s1_exp_q       <= 8'd0;
         s1_man_big_q   <= 24'd0;
         s1_man_small_q <= 24'd0;
         s1_diff_q      <= 8'd0;
      end else begin
         s1_special_q   <= s1_special_d;
         s1_spec_res_q  <= s1_spec_res_d;
         s1_sign_q      <= s1_sign_d;
         s1_sub_q       <= s1_sub_d;
         s1_exp_q       <= s1_exp_d;
         s1_man_big_q   <= s1_man_big_d;
         s1_man_small_q <= s1_man_small_d;
         s1_diff_q      <= s1_diff_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2: alignment with guard/round/sticky, significand add/subtract
   // ---------------------------------------------------------------------------
   logic [26:0] small_ext;
   logic [26:0] aligned;
   logic [26:0] big_ext;
   logic [27:0] s2_sum_d;

   assign small_ext = {s1_man_small_q, 3'b000};
   assign big_ext   = {s1_man_big_q, 3'b000};

   // Shift the smaller significand right and fold every bit shifted out into the sticky bit.
   always_comb begin
      aligned = 27'd0;
      if (s1_diff_q >= 8'd26) begin
         aligned = {26'd0, |s1_man_small_q};
      end else begin
         aligned    = small_ext >> s1_diff_q;
         aligned[0] = aligned[0] | (|(small_ext & ~(27'h7FF_FFFF << s1_diff_q)));
      end
      // The larger magnitude comes first, so a subtraction never goes negative.
      if (s1_sub_q) begin
         s2_sum_d = {1'b0, big_ext} - {1'b0, aligned};
      end else begin
         s2_sum_d = {1'b0, big_ext} + {1'b0, aligned};
      end
   end

   logic        s2_special_q;
   logic [31:0] s2_spec_res_q;
   logic        s2_sign_q;
   logic [7:0]  s2_exp_q;
   logic [27:0] s2_sum_q;

   // Stage 2 pipeline register.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_special_q  <= 1'b0;
         s2_spec_res_q <= 32'd0;
         s2_sign_q     <= 1'b0;
         s2_exp_q      <= 8'd0;
         s2_sum_q      <= 28'd0;
      end else begin
         s2_special_q  <= s1_special_q;
         s2_spec_res_q <= s1_spec_res_q;
         s2_sign_q     <= s1_sign_q;
         s2_exp_q      <= s1_exp_q;
         s2_sum_q      <= s2_sum_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 3: normalize, round to nearest even, pack
   // ---------------------------------------------------------------------------
   logic [4:0]        lz;
   logic [26:0]       norm;
   logic signed [9:0] e_norm;
   logic signed [9:0] e_fin;
   logic              round_up;
   logic [24:0]       mant;
   logic [23:0]       mant_fin;
   logic [31:0]       vres_d;

   // Count leading zeros of the in-range sum; the highest set bit wins.
   always_comb begin
      lz = 5'd0;
      for (int i = 0; i < 27; i++) begin
         if (s2_sum_q[i]) lz = 5'(26 - i);
      end
   end

   // Normalize, round and choose between finite, zero, infinity and special results.
   always_comb begin
      if (s2_sum_q[27]) begin
         // Carry out of the addition: shift right once, keep the lost bit as sticky.
         norm   = {s2_sum_q[27:2], s2_sum_q[1] | s2_sum_q[0]};
         e_norm = $signed({2'b00, s2_exp_q}) + 10'sd1;
      end else begin
         norm   = s2_sum_q[26:0] << lz;
         e_norm = $signed({2'b00, s2_exp_q}) - $signed({5'd0, lz});
      end

      round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      mant     = {1'b0, norm[26:3]} + {24'd0, round_up};
      if (mant[24]) begin
         mant_fin = mant[24:1];
         e_fin    = e_norm + 10'sd1;
      end else begin
         mant_fin = mant[23:0];
         e_fin    = e_norm;
      end

      if (s2_special_q) begin
         vres_d = s2_spec_res_q;
      end else if (s2_sum_q == 28'd0) begin
         vres_d = 32'd0;
      end else if (e_norm <= 10'sd0) begin
         vres_d = {s2_sign_q, 31'd0};
      end else if (e_fin >= 10'sd255) begin
         vres_d = {s2_sign_q, EXP_MAX, 23'd0};
      end else begin
         vres_d = {s2_sign_q, e_fin[7:0], mant_fin[22:0]};
      end
   end

   // Output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         vres <= 32'd0;
      end else begin
         vres <= vres_d;
      end
   end

endmodule

// File: tb/tb_float_addsub.sv
// -----------------------------------------------------------------------------
// tb_float_addsub: directed and random checks of float_addsub. Expected results
// come from a reference model that adds in double precision and rounds the
// sum to binary32. A four-entry history tracks the three-edge latency.
// -----------------------------------------------------------------------------
module tb_float_addsub;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic        clk;
   logic        rst;
   logic [31:0] v1, v2;
   logic        op;
   logic [31:0] vres;

   int total = 0;
   int bad   = 0;

   logic [31:0] hist_exp  [4];
   logic [31:0] hist_want [4];
   logic        hist_has  [4];
   string       hist_tag  [4];

   float_addsub dut (
      .clk  (clk),
      .rst  (rst),
      .v1   (v1),
      .v2   (v2),
      .op   (op),
      .vres (vres)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // binary32 -> binary64 bit pattern; subnormals become signed zero.
   function automatic logic [63:0] f2d(input logic [31:0] f);
      logic [10:0] e11;
      if (f[30:23] == 8'd0) return {f[31], 63'd0};
      e11 = {3'b000, f[30:23]} + 11'd896;
      return {f[31], e11, f[22:0], 29'd0};
   endfunction

   // Reference: exact-enough double sum, then one round-to-nearest-even to binary32.
   function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic o);
      logic [31:0] bb;
      logic        a_nan, b_nan, a_inf, b_inf;
      real         rs;
      logic [63:0] d;
      int          e;
      logic [24:0] m;
      logic [28:0] rem;
      bb    = {b[31] ^ o, b[30:0]};
      a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan = (bb[30:23] == 8'hFF) && (bb[22:0] != 23'd0);
      a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf = (bb[30:23] == 8'hFF) && (bb[22:0] == 23'd0);
      if (a_nan || b_nan) return QNAN;
      if (a_inf && b_inf) return (a[31] == bb[31]) ? a : QNAN;
      if (a_inf) return a;
      if (b_inf) return bb;
      rs = $bitstoreal(f2d(a)) + $bitstoreal(f2d(bb));
      d  = $realtobits(rs);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      e = int'(d[62:52]) - 1023;
      if (e < -126) return {d[63], 31'd0};
      m   = {2'b01, d[51:29]};
      rem = d[28:0];
      if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) m = m + 25'd1;
      if (m[24]) begin
         m = m >> 1;
         e = e + 1;
      end
      if (e > 127) return {d[63], 8'hFF, 23'd0};
      return {d[63], 8'(e + 127), m[22:0]};
   endfunction

   // Random operand; near_exp >= 0 keeps the exponent close to a given one.
   function automatic logic [31:0] rand_f(input int near_exp);
      int k;
      int e;
      k = $urandom_range(0, 19);
      case (k)
         0: return 32'h0000_0000;
         1: return 32'h8000_0000;
         2: return 32'h7F80_0000;
         3: return 32'hFF80_0000;
         4: return {1'($urandom_range(0, 1)), 8'hFF, 23'h40_0000 | 23'($urandom)};
         5: return {1'($urandom_range(0, 1)), 8'h00, 23'($urandom) | 23'd1};
         default: begin
            if (near_exp < 0) e = $urandom_range(1, 254);
            else e = near_exp + int'($urandom_range(0, 60)) - 30;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
            return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
         end
      endcase
   endfunction

   // One clock: drive inputs, clock, advance the history, check vres.
   task automatic tick(input logic [31:0] a, input logic [31:0] b, input logic o, input logic r,
                       input logic has_want, input logic [31:0] want, input string tag);
      v1  = a;
      v2  = b;
      op  = o;
      rst = r;
      @(posedge clk);
      for (int i = 3; i > 0; i--) begin
         hist_exp[i]  = hist_exp[i-1];
         hist_want[i] = hist_want[i-1];
         hist_has[i]  = hist_has[i-1];
         hist_tag[i]  = hist_tag[i-1];
      end
      hist_exp[0]  = ref_add(a, b, o);
      hist_want[0] = want;
      hist_has[0]  = has_want;
      hist_tag[0]  = tag;
      if (r) begin
         for (int i = 0; i < 4; i++) begin
            hist_exp[i] = 32'd0;
            hist_has[i] = 1'b0;
         end
      end
      #1;
      total++;
      assert (vres === hist_exp[3])
      else begin
         bad++;
         $error("FAIL model[%s] vres=%h expected=%h", hist_tag[3], vres, hist_exp[3]);
      end
      if (r) begin
         total++;
         assert (vres === 32'd0)
         else begin
            bad++;
            $error("FAIL reset vres=%h expected=00000000", vres);
         end
      end
      if (hist_has[3]) begin
         total++;
         assert (vres === hist_want[3])
         else begin
            bad++;
            $error("FAIL %s vres=%h expected=%h", hist_tag[3], vres, hist_want[3]);
         end
      end
      @(negedge clk);
   endtask

   task automatic go(input logic [31:0] a, input logic [31:0] b, input logic o);
      tick(a, b, o, 1'b0, 1'b0, 32'd0, "stream");
   endtask

   task automatic chk(input logic [31:0] a, input logic [31:0] b, input logic o,
                      input logic [31:0] want, input string tag);
      tick(a, b, o, 1'b0, 1'b1, want, tag);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        ro;
      for (int i = 0; i < 4; i++) begin
         hist_exp[i]  = 32'd0;
         hist_want[i] = 32'd0;
         hist_has[i]  = 1'b0;
         hist_tag[i]  = "idle";
      end
      rst = 1'b1;
      v1  = 32'd0;
      v2  = 32'd0;
      op  = 1'b0;

      // Reset held for two edges with the first operands already driven.
      tick(32'hC0E8_0000, 32'hC2F6_CCCD, 1'b1, 1'b1, 1'b0, 32'd0, "reset");
      tick(32'hC0E8_0000, 32'hC2F6_CCCD, 1'b1, 1'b1, 1'b0, 32'd0, "reset");

      // Directed results, streamed back to back.
      chk(32'hC0E8_0000, 32'hC2F6_CCCD, 1'b1, 32'h42E8_4CCD, "sub_neg");
      chk(32'hC0E8_0000, 32'hC2F6_CCCD, 1'b0, 32'hC302_A666, "add_carry_tie");
      chk(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, "cancel_zero");
      chk(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, "tie_even");
      chk(32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, "tie_up");
      chk(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, "inf_minus_inf");
      chk(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, "overflow");
      chk(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, "nan_in");
      chk(32'h3F80_0001, 32'h3F80_0000, 1'b1, 32'h3400_0000, "lzc_cancel");
      chk(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, "stream0");
      chk(32'h40A0_0000, 32'h4040_0000, 1'b1, 32'h4000_0000, "stream1");
      chk(32'hBFC0_0000, 32'h3F00_0000, 1'b0, 32'hBF80_0000, "stream2");
      chk(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, "neg_zero_add");
      chk(32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, "neg_zero_sub");
      chk(32'h0000_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, "zero_operand");
      chk(32'h0040_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, "subnorm_flush");
      chk(32'hFF80_0000, 32'h3F80_0000, 1'b1, 32'hFF80_0000, "inf_finite");
      go(32'd0, 32'd0, 1'b0);
      go(32'd0, 32'd0, 1'b0);
      go(32'd0, 32'd0, 1'b0);

      // Reset in the middle of a stream discards everything in flight.
      go(32'h3F80_0000, 32'h4000_0000, 1'b0);
      go(32'h40A0_0000, 32'h4040_0000, 1'b1);
      tick(32'hBFC0_0000, 32'h3F00_0000, 1'b0, 1'b1, 1'b0, 32'd0, "mid_reset");
      for (int i = 0; i < 4; i++) chk(32'd0, 32'd0, 1'b0, 32'd0, "no_stale");

      // Random operands against the reference model.
      for (int i = 0; i < 400; i++) begin
         ra = rand_f(-1);
         ro = 1'($urandom_range(0, 1));
         if ((i % 4) == 0 && ra[30:23] != 8'd0 && ra[30:23] != 8'hFF) begin
            rb = {ra[31], ra[30:0] ^ 31'($urandom_range(0, 255))};
            ro = 1'b1;
         end else begin
            rb = rand_f(int'(ra[30:23]));
         end
         go(ra, rb, ro);
      end
      go(32'd0, 32'd0, 1'b0);
      go(32'd0, 32'd0, 1'b0);
      go(32'd0, 32'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
